mbist_march_ctrl: RTL and testbench



---
 rtl/mbist_pkg.sv | 43 ++++
 rtl/march_addr_gen.sv | 32 +++
 rtl/mbist_march_ctrl.sv | 148 ++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM encoding, op kinds
// and the per-element table describing the six March C- elements.
package mbist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_kind_t;

  localparam int NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

  // E0 (w0) and E5 (r0) issue one op per address; E1..E4 issue read then write.
  function automatic int unsigned elem_ops(input logic [2:0] e);
    case (e)
      3'd1, 3'd2, 3'd3, 3'd4: elem_ops = 2;
      default:                elem_ops = 1;
    endcase
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    elem_down = (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic op_kind_t elem_op(input logic [2:0] e, input logic phase);
    elem_op = OP_NONE;
    if (!phase) begin
      if (e == 3'd0)           elem_op = OP_WRITE;
      else if (e <= LAST_ELEM) elem_op = OP_READ;
    end else if (elem_ops(e) == 2) begin
      elem_op = OP_WRITE;
    end
  endfunction

  // Background bit expected by the element's read (0 = B0, 1 = B1).
  function automatic logic elem_read_bg(input logic [2:0] e);
    elem_read_bg = (e == 3'd2) || (e == 3'd4);
  endfunction

  // Background bit written by the element's write.
  function automatic logic elem_write_bg(input logic [2:0] e);
    elem_write_bg = (e == 3'd1) || (e == 3'd3);
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for March elements: loads 0 or N-1, steps in the
// direction captured at load time, and flags the final address of the sweep.
module march_addr_gen #(
  parameter int addr = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            down,
  input  logic            step,
  output logic [addr-1:0] cnt,
  output logic            last
);

  logic dir_q;

  // Direction is latched at load so that last never depends on load/down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      cnt   <= down ? '1 : '0;
      dir_q <= down;
    end else if (step) begin
      cnt <= dir_q ? cnt - 1'b1 : cnt + 1'b1;
    end
  end

  assign last = dir_q ? (cnt == '0) : (cnt == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: drives one op per cycle into a single-port memory,
// compares reads two cycles later and latches first-failure diagnostics.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int addr = 4,
  parameter int data = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [addr-1:0] fail_addr,
  output logic [2:0]      fail_elem,
  output logic [data-1:0] fail_mask,
  output logic            mem_wen,
  output logic            mem_ren,
  output logic [addr-1:0] mem_addr,
  output logic [data-1:0] mem_din,
  input  logic [data-1:0] mem_dout
);

  state_t          state, nxt_state;
  logic [2:0]      elem, nxt_elem, elem_inc;
  logic            phase, nxt_phase;
  logic            load, load_down, step, issue, clr_diag;
  op_kind_t        nxt_op;
  logic            addr_last;
  logic [addr-1:0] cur_addr;

  logic            rd_v;
  logic [data-1:0] rd_exp;
  logic [addr-1:0] rd_addr;
  logic [2:0]      rd_elem;

  march_addr_gen #(.addr(addr)) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .down (load_down),
    .step (step),
    .cnt  (cur_addr),
    .last (addr_last)
  );

  assign mem_addr = cur_addr;
  assign elem_inc = elem + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  // Decides the op to drive after the coming edge; the address counter
  // advances only once both ops of the current address have issued.
  always_comb begin
    nxt_state = state;
    nxt_elem  = elem;
    nxt_phase = phase;
    load      = 1'b0;
    load_down = 1'b0;
    step      = 1'b0;
    issue     = 1'b0;
    clr_diag  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nxt_state = ST_RUN;
          nxt_elem  = 3'd0;
          nxt_phase = 1'b0;
          load      = 1'b1;
          load_down = elem_down(3'd0);
          issue     = 1'b1;
          clr_diag  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!phase && elem_ops(elem) == 2) begin
          nxt_phase = 1'b1;
          issue     = 1'b1;
        end else if (!addr_last) begin
          nxt_phase = 1'b0;
          step      = 1'b1;
          issue     = 1'b1;
        end else if (elem == LAST_ELEM) begin
          nxt_state = ST_DRAIN;
          nxt_phase = 1'b0;
        end else begin
          nxt_elem  = elem_inc;
          nxt_phase = 1'b0;
          load      = 1'b1;
          load_down = elem_down(elem_inc);
          issue     = 1'b1;
        end
      end
      ST_DRAIN: nxt_state = ST_DONE;
      default:  nxt_state = ST_IDLE;
    endcase
    nxt_op = issue ? elem_op(nxt_elem, nxt_phase) : OP_NONE;
  end

  // Outputs, the one-stage read tag pipeline and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem      <= '0;
      phase     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_mask <= '0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_din   <= '0;
      rd_v      <= 1'b0;
      rd_exp    <= '0;
      rd_addr   <= '0;
      rd_elem   <= '0;
    end else begin
      elem    <= nxt_elem;
      phase   <= nxt_phase;
      busy    <= (nxt_state == ST_RUN) || (nxt_state == ST_DRAIN);
      done    <= (nxt_state == ST_DONE);
      mem_wen <= (nxt_op == OP_WRITE);
      mem_ren <= (nxt_op == OP_READ);
      mem_din <= (nxt_op == OP_WRITE && elem_write_bg(nxt_elem)) ? '1 : '0;
      rd_v    <= mem_ren;
      rd_exp  <= elem_read_bg(elem) ? '1 : '0;
      rd_addr <= mem_addr;
      rd_elem <= elem;
      if (clr_diag) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_mask <= '0;
      end else if (rd_v && !fail && (mem_dout != rd_exp)) begin
        fail      <= 1'b1;
        fail_addr <= rd_addr;
        fail_elem <= rd_elem;
        fail_mask <= mem_dout ^ rd_exp;
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: fault-injectable memory model, expected-op
// scoreboard and directed runs covering clean, faulty and reset scenarios.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_mask;
  logic       mem_wen, mem_ren;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int ops_seen = 0;
  bit mon_en = 1'b0;
  logic [13:0] expq[$];

  logic [7:0] mem [16];
  logic [3:0] sa0_addr = 4'd0, sa1_addr = 4'd0;
  logic [7:0] sa0_mask = 8'h00, sa1_mask = 8'h00;
  bit         alias_en = 1'b0;

  bit el_down[6] = '{0, 0, 0, 1, 1, 0};
  bit el_two[6]  = '{0, 1, 1, 1, 1, 0};
  bit el_wbg[6]  = '{0, 1, 0, 1, 0, 0};

  mbist_march_ctrl #(.addr(4), .data(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_mask (fail_mask),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;

  // Registered single-port memory with optional stuck-at bits and an alias.
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr] <= mem_din;
      if (alias_en && mem_addr == 4'd3) mem[12] <= mem_din;
    end
    if (mem_ren) begin
      mem_dout <= (mem[mem_addr]
                   & ~((mem_addr == sa0_addr) ? sa0_mask : 8'h00))
                  | ((mem_addr == sa1_addr) ? sa1_mask : 8'h00);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {busy, done, fail, fail_addr, fail_elem, fail_mask,
            mem_wen, mem_ren, mem_addr, mem_din};
  endfunction

  // Reference March C- op stream: {wen, ren, addr, din} per op.
  task automatic pushRun();
    logic [3:0] a;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        a = el_down[e] ? 4'(15 - i) : 4'(i);
        if (e == 0) expq.push_back({1'b1, 1'b0, a, 8'h00});
        else        expq.push_back({1'b0, 1'b1, a, 8'h00});
        if (el_two[e]) expq.push_back({1'b1, 1'b0, a, el_wbg[e] ? 8'hFF : 8'h00});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("wen_ren_excl", {31'b0, mem_wen & mem_ren}, 32'd0);
      if (mem_wen || mem_ren) begin
        ops_seen++;
        if (expq.size() == 0)
          checkOutput("extra_op", {18'b0, mem_wen, mem_ren, mem_addr, mem_din}, 32'd0);
        else
          checkOutput("op_seq", {18'b0, mem_wen, mem_ren, mem_addr, mem_din},
                      {18'b0, expq.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input bit accepted);
    start = 1'b1;
    if (accepted) begin
      pushRun();
      ops_seen = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int repulse_at, output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == repulse_at);
    end
    start = 1'b0;
  endtask

  task automatic endOfRun(input string tag, input int cyc, input logic [31:0] exp_fail,
                          input logic [31:0] exp_elem, input logic [31:0] exp_addr,
                          input logic [31:0] exp_mask);
    $display("[TB] end of run %s", tag);
    checkOutput({tag, "_cycles"}, cyc, 161);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_ops"}, ops_seen, 160);
    checkOutput({tag, "_pending"}, expq.size(), 0);
    checkOutput({tag, "_fail"}, {31'b0, fail}, exp_fail);
    checkOutput({tag, "_elem"}, {29'b0, fail_elem}, exp_elem);
    checkOutput({tag, "_addr"}, {28'b0, fail_addr}, exp_addr);
    checkOutput({tag, "_mask"}, {24'b0, fail_mask}, exp_mask);
  endtask

  initial begin
    int cyc;
    int ops_before;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", allOutputs(), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    applyStimulus(1'b1);
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    waitDone(-1, cyc);
    endOfRun("clean", cyc, 0, 0, 0, 0);

    sa0_addr = 4'd5; sa0_mask = 8'h08;
    applyStimulus(1'b1);
    waitDone(-1, cyc);
    endOfRun("sa0_a5_b3", cyc, 1, 2, 5, 32'h08);

    sa0_mask = 8'h00;
    applyStimulus(1'b1);
    checkOutput("restart_clears", {29'b0, done, fail, |fail_mask}, 32'd0);
    waitDone(-1, cyc);
    endOfRun("repaired", cyc, 0, 0, 0, 0);

    sa1_addr = 4'd0; sa1_mask = 8'h01;
    applyStimulus(1'b1);
    waitDone(-1, cyc);
    endOfRun("sa1_a0_b0", cyc, 1, 1, 0, 32'h01);
    sa1_mask = 8'h00;

    alias_en = 1'b1;
    applyStimulus(1'b1);
    waitDone(-1, cyc);
    endOfRun("alias_3_12", cyc, 1, 1, 12, 32'hFF);
    alias_en = 1'b0;

    applyStimulus(1'b1);
    waitDone(30, cyc);
    endOfRun("repulse", cyc, 0, 0, 0, 0);

    applyStimulus(1'b1);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expq.delete();
    rst = 1'b0;
    checkOutput("rst_midrun", allOutputs(), 32'd0);
    ops_before = ops_seen;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no_ops_after_rst", ops_seen - ops_before, 0);
    checkOutput("idle_after_rst", {30'b0, busy, done}, 32'd0);

    applyStimulus(1'b1);
    waitDone(-1, cyc);
    endOfRun("after_rst", cyc, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
